// File: rtl/instr_sequencer.sv
// Multicycle sequencer: accepts one 16-bit instruction over valid/ready and walks it
// through DECODE, READ, EXEC, WRITE, DONE, driving register-bank and ALU controls.
module instr_sequencer #(
  parameter int RF_LAT  = 1,
  parameter int ALU_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [3:0]  reg_a_addr,
  output logic [3:0]  reg_b_addr,
  output logic [3:0]  reg_c_addr,
  output logic [3:0]  alu_op,
  output logic [15:0] imm,
  output logic        imm_sel,
  input  logic [15:0] alu_result,
  output logic [15:0] wr_data,
  output logic        reg_we,
  output logic        busy,
  output logic        done,
  output logic        illegal,
  output logic [15:0] retired_cnt
);

  typedef enum logic [2:0] {IDLE, DECODE, READ, EXEC, WRITE, DONE} state_t;

  state_t      r_state, w_state_next;
  logic [2:0]  r_cnt, w_cnt_next;
  logic [15:0] r_instr;
  logic [3:0]  r_reg_a, r_reg_b, r_reg_c, r_alu_op;
  logic [15:0] r_imm, r_wr_data, r_retired_cnt;
  logic        r_imm_sel, r_reg_we, r_done, r_illegal;
  logic        w_accept, w_illegal_op, w_itype;

  assign w_accept     = (r_state == IDLE) && instr_valid;
  assign w_illegal_op = (r_instr[15:12] > 4'd10);
  assign w_itype      = (r_instr[15:12] >= 4'd6);

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      IDLE:   if (instr_valid) w_state_next = DECODE;
      DECODE: begin
        if (w_illegal_op) begin
          w_state_next = DONE;
        end else begin
          w_state_next = READ;
          w_cnt_next   = 3'(RF_LAT - 1);
        end
      end
      READ: begin
        if (r_cnt == 3'd0) begin
          w_state_next = EXEC;
          w_cnt_next   = 3'(ALU_LAT - 1);
        end else begin
          w_cnt_next = r_cnt - 3'd1;
        end
      end
      EXEC: begin
        if (r_cnt == 3'd0) w_state_next = WRITE;
        else               w_cnt_next   = r_cnt - 3'd1;
      end
      WRITE:   w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Strobes are computed from the next state so they are registered yet aligned to it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_instr       <= '0;
      r_reg_a       <= '0;
      r_reg_b       <= '0;
      r_reg_c       <= '0;
      r_alu_op      <= '0;
      r_imm         <= '0;
      r_imm_sel     <= 1'b0;
      r_wr_data     <= '0;
      r_reg_we      <= 1'b0;
      r_done        <= 1'b0;
      r_illegal     <= 1'b0;
      r_retired_cnt <= '0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_reg_we  <= (w_state_next == WRITE);
      r_done    <= (w_state_next == DONE);
      r_illegal <= (w_state_next == DONE) && (r_state == DECODE) && w_illegal_op;
      if (w_accept) r_instr <= instr;
      if ((r_state == DECODE) && !w_illegal_op) begin
        r_alu_op <= r_instr[15:12];
        r_reg_c  <= r_instr[11:8];
        r_reg_b  <= r_instr[3:0];
        if (w_itype) begin
          r_imm     <= {12'b0, r_instr[7:4]};
          r_imm_sel <= 1'b1;
          r_reg_a   <= 4'd0;
        end else begin
          r_imm     <= '0;
          r_imm_sel <= 1'b0;
          r_reg_a   <= r_instr[7:4];
        end
      end
      if ((r_state == EXEC) && (r_cnt == 3'd0)) r_wr_data <= alu_result;
      if ((r_state == DONE) && !r_illegal) r_retired_cnt <= r_retired_cnt + 16'd1;
    end
  end

  assign instr_ready = (r_state == IDLE);
  assign busy        = (r_state != IDLE);
  assign reg_a_addr  = r_reg_a;
  assign reg_b_addr  = r_reg_b;
  assign reg_c_addr  = r_reg_c;
  assign alu_op      = r_alu_op;
  assign imm         = r_imm;
  assign imm_sel     = r_imm_sel;
  assign wr_data     = r_wr_data;
  assign reg_we      = r_reg_we;
  assign done        = r_done;
  assign illegal     = r_illegal;
  assign retired_cnt = r_retired_cnt;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: default-latency instance plus an RF_LAT=3/ALU_LAT=2 instance.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] instr, instr2, alu_result;
  logic        instr_valid, valid2;

  logic        instr_ready, imm_sel, reg_we, busy, done, illegal;
  logic [3:0]  reg_a_addr, reg_b_addr, reg_c_addr, alu_op;
  logic [15:0] imm, wr_data, retired_cnt;

  logic        d2_ready, d2_imm_sel, d2_reg_we, d2_busy, d2_done, d2_illegal;
  logic [3:0]  d2_reg_a, d2_reg_b, d2_reg_c, d2_alu_op;
  logic [15:0] d2_imm, d2_wr_data, d2_retired;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_sequencer u_dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .reg_a_addr(reg_a_addr), .reg_b_addr(reg_b_addr),
    .reg_c_addr(reg_c_addr), .alu_op(alu_op), .imm(imm), .imm_sel(imm_sel),
    .alu_result(alu_result), .wr_data(wr_data), .reg_we(reg_we), .busy(busy),
    .done(done), .illegal(illegal), .retired_cnt(retired_cnt)
  );

  instr_sequencer #(.RF_LAT(3), .ALU_LAT(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .instr(instr2), .instr_valid(valid2),
    .instr_ready(d2_ready), .reg_a_addr(d2_reg_a), .reg_b_addr(d2_reg_b),
    .reg_c_addr(d2_reg_c), .alu_op(d2_alu_op), .imm(d2_imm), .imm_sel(d2_imm_sel),
    .alu_result(alu_result), .wr_data(d2_wr_data), .reg_we(d2_reg_we), .busy(d2_busy),
    .done(d2_done), .illegal(d2_illegal), .retired_cnt(d2_retired)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one instruction to the selected instance and records write/done timing
  // as cycle offsets from the accept edge (k=1 is the first cycle after it).
  task automatic run_instr(input bit sel, input logic [15:0] ins, input logic [15:0] res,
                           input bit vary, output int we_cnt, output int we_at,
                           output int done_at, output logic [15:0] wd, output logic ill);
    we_cnt = 0; we_at = -1; done_at = -1; wd = '0; ill = 1'b0;
    if (sel) begin instr2 = ins; valid2 = 1'b1; end
    else     begin instr = ins;  instr_valid = 1'b1; end
    alu_result = res;
    step();
    instr_valid = 1'b0; valid2 = 1'b0;
    instr = 16'hFFFF; instr2 = 16'hFFFF;
    for (int k = 1; k <= 20; k++) begin
      if (vary) alu_result = 16'h1000 + 16'(k);
      if (sel ? d2_reg_we : reg_we) begin
        we_cnt++; we_at = k; wd = sel ? d2_wr_data : wr_data;
      end
      if (sel ? d2_done : done) begin
        done_at = k; ill = sel ? d2_illegal : illegal;
      end
      if (sel ? d2_ready : instr_ready) break;
      step();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; instr = '0; instr2 = '0; instr_valid = 1'b0; valid2 = 1'b0; alu_result = '0;
    step(); step();
    checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", instr_ready); end
    checks++; if ({busy, reg_we, done, illegal, imm_sel} !== 5'b0) begin errors++; $display("FAIL reset_flags: got %b expected 00000", {busy, reg_we, done, illegal, imm_sel}); end
    checks++; if ({reg_a_addr, reg_b_addr, reg_c_addr, alu_op} !== 16'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0000", {reg_a_addr, reg_b_addr, reg_c_addr, alu_op}); end
    checks++; if ({imm, wr_data, retired_cnt} !== 48'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", {imm, wr_data, retired_cnt}); end
    checks++; if (d2_ready !== 1'b1) begin errors++; $display("FAIL reset_ready2: got %b expected 1", d2_ready); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_add();
    int wc, wa, da; logic [15:0] wd; logic il;
    run_instr(1'b0, 16'h0312, 16'h0007, 1'b0, wc, wa, da, wd, il);
    checks++; if ({reg_a_addr, reg_b_addr, reg_c_addr} !== 12'h123) begin errors++; $display("FAIL add_addr: got %h expected 123", {reg_a_addr, reg_b_addr, reg_c_addr}); end
    checks++; if (imm_sel !== 1'b0) begin errors++; $display("FAIL add_imm_sel: got %b expected 0", imm_sel); end
    checks++; if (wc !== 1 || wa !== 4) begin errors++; $display("FAIL add_we: got count %0d at %0d expected 1 at 4", wc, wa); end
    checks++; if (wd !== 16'h0007) begin errors++; $display("FAIL add_wr_data: got %h expected 0007", wd); end
    checks++; if (da !== 5 || il !== 1'b0) begin errors++; $display("FAIL add_done: got at %0d illegal %b expected 5 illegal 0", da, il); end
    checks++; if (retired_cnt !== 16'd1) begin errors++; $display("FAIL add_retired: got %0d expected 1", retired_cnt); end
  endtask

  task automatic test_itype();
    int wc, wa, da; logic [15:0] wd; logic il;
    run_instr(1'b0, 16'h6A5B, 16'h1234, 1'b0, wc, wa, da, wd, il);
    checks++; if (imm !== 16'h0005 || imm_sel !== 1'b1) begin errors++; $display("FAIL itype_imm: got %h sel %b expected 0005 sel 1", imm, imm_sel); end
    checks++; if (alu_op !== 4'h6 || reg_c_addr !== 4'hA || reg_b_addr !== 4'hB || reg_a_addr !== 4'h0) begin
      errors++; $display("FAIL itype_fields: got op %h c %h b %h a %h expected 6 A B 0", alu_op, reg_c_addr, reg_b_addr, reg_a_addr); end
    checks++; if (wc !== 1 || wd !== 16'h1234) begin errors++; $display("FAIL itype_write: got count %0d data %h expected 1 1234", wc, wd); end
    checks++; if (retired_cnt !== 16'd2) begin errors++; $display("FAIL itype_retired: got %0d expected 2", retired_cnt); end
  endtask

  task automatic test_illegal();
    int wc, wa, da; logic [15:0] wd; logic il;
    run_instr(1'b0, 16'hC123, 16'h5555, 1'b0, wc, wa, da, wd, il);
    checks++; if (wc !== 0) begin errors++; $display("FAIL illegal_we: got %0d writes expected 0", wc); end
    checks++; if (da !== 2 || il !== 1'b1) begin errors++; $display("FAIL illegal_done: got at %0d illegal %b expected 2 illegal 1", da, il); end
    checks++; if (retired_cnt !== 16'd2) begin errors++; $display("FAIL illegal_retired: got %0d expected 2", retired_cnt); end
    checks++; if (alu_op !== 4'h6 || reg_c_addr !== 4'hA) begin errors++; $display("FAIL illegal_hold: got op %h c %h expected 6 A", alu_op, reg_c_addr); end
  endtask

  task automatic test_latency();
    int wc, wa, da; logic [15:0] wd; logic il;
    run_instr(1'b1, 16'h1456, 16'h0000, 1'b1, wc, wa, da, wd, il);
    checks++; if (da !== 8) begin errors++; $display("FAIL lat_done: got at %0d expected 8", da); end
    checks++; if (wc !== 1 || wa !== 7) begin errors++; $display("FAIL lat_we: got count %0d at %0d expected 1 at 7", wc, wa); end
    checks++; if (wd !== 16'h1006) begin errors++; $display("FAIL lat_wr_data: got %h expected 1006", wd); end
    checks++; if (d2_retired !== 16'd1 || d2_ready !== 1'b1) begin errors++; $display("FAIL lat_retired: got %0d ready %b expected 1 ready 1", d2_retired, d2_ready); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] seq [3];
    int acc [3];
    logic [3:0] wc [3];
    int n, m;
    seq[0] = 16'h1123; seq[1] = 16'h2456; seq[2] = 16'h3789;
    n = 0; m = 0;
    alu_result = 16'h00AA;
    instr_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (reg_we && m < 3) begin wc[m] = reg_c_addr; m++; end
      if (instr_ready) begin
        if (n < 3) begin acc[n] = i; instr = seq[n]; n++; end
        else instr_valid = 1'b0;
      end else begin
        instr = 16'hF0F0 ^ 16'(i);
      end
      step();
    end
    instr_valid = 1'b0;
    checks++; if (n !== 3 || m !== 3) begin errors++; $display("FAIL b2b_count: got %0d accepts %0d writes expected 3 3", n, m); end
    checks++; if (acc[1] - acc[0] !== 6 || acc[2] - acc[1] !== 6) begin errors++; $display("FAIL b2b_spacing: got %0d %0d expected 6 6", acc[1] - acc[0], acc[2] - acc[1]); end
    checks++; if ({wc[0], wc[1], wc[2]} !== 12'h147) begin errors++; $display("FAIL b2b_rc: got %h expected 147", {wc[0], wc[1], wc[2]}); end
    checks++; if (retired_cnt !== 16'd5) begin errors++; $display("FAIL b2b_retired: got %0d expected 5", retired_cnt); end
  endtask

  task automatic test_reset_midop();
    int we_seen;
    instr = 16'h0312; instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    step(); step();
    rst_n = 1'b0;
    step();
    checks++; if (reg_we !== 1'b0 || busy !== 1'b0 || instr_ready !== 1'b1) begin errors++; $display("FAIL midop_ctrl: got we %b busy %b ready %b expected 0 0 1", reg_we, busy, instr_ready); end
    checks++; if (retired_cnt !== 16'd0 || alu_op !== 4'd0 || reg_c_addr !== 4'd0) begin errors++; $display("FAIL midop_regs: got cnt %0d op %h c %h expected 0 0 0", retired_cnt, alu_op, reg_c_addr); end
    rst_n = 1'b1;
    we_seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (reg_we) we_seen++;
      step();
    end
    checks++; if (we_seen !== 0 || instr_ready !== 1'b1) begin errors++; $display("FAIL midop_after: got writes %0d ready %b expected 0 1", we_seen, instr_ready); end
  endtask

  task automatic test_wrap();
    int wc, wa, da; logic [15:0] wd; logic il;
    force u_dut.r_retired_cnt = 16'hFFFF;
    step();
    release u_dut.r_retired_cnt;
    step();
    checks++; if (retired_cnt !== 16'hFFFF) begin errors++; $display("FAIL wrap_preset: got %h expected FFFF", retired_cnt); end
    run_instr(1'b0, 16'h0312, 16'h0001, 1'b0, wc, wa, da, wd, il);
    checks++; if (retired_cnt !== 16'h0000) begin errors++; $display("FAIL wrap_cnt: got %h expected 0000", retired_cnt); end
    checks++; if (wc !== 1) begin errors++; $display("FAIL wrap_we: got %0d writes expected 1", wc); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_itype();
    test_illegal();
    test_latency();
    test_back_to_back();
    test_reset_midop();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Multicycle control unit that sequences one 16-bit instruction at a time through the register bank and ALU datapath.
- Instruction format: opcode[15:12], rc[11:8], field1[7:4], rb[3:0].
  - R-type opcodes 0..5: field1 = ra.
  - I-type opcodes 6..10: field1 = 4-bit immediate.
- Replaces the switch/KEY-driven ad-hoc sequencing at the top level. Drives register addresses, ALU opcode, immediate select and the single write-enable pulse.
- Accepts instructions over a valid/ready handshake from a fetch source (switch debouncer or instruction ROM).

Parameters:
RF_LAT, 1, cycles from address change to valid register read data (1..4)
ALU_LAT, 1, cycles from operand/opcode change to valid alu_result (1..4)

Ports:
clk  in  1  system clock (CLOCK_50 at top level)
rst_n  in  1  synchronous reset, active-low
instr  in  16  instruction word
instr_valid  in  1  instr is valid
instr_ready  out  1  sequencer can accept an instruction
reg_a_addr  out  4  register bank read port A address
reg_b_addr  out  4  register bank read port B address
reg_c_addr  out  4  register bank write address
alu_op  out  4  ALU opcode
imm  out  16  zero-extended immediate
imm_sel  out  1  1 = I-type, bank uses imm for operand
alu_result  in  16  ALU result
wr_data  out  16  data to register bank
reg_we  out  1  register bank write enable, one-cycle pulse
busy  out  1  instruction in flight
done  out  1  one-cycle pulse at instruction end
illegal  out  1  held with done when opcode is 11..15
retired_cnt  out  16  count of legal instructions completed

Behaviour:
- Clock and reset: single clock; reset is synchronous and active-low (rst_n sampled on the rising edge of clk).
- Reset values: every output 0 except instr_ready = 1; state IDLE; internal counters 0.
- Reset mid-instruction: aborts at that edge; reg_we low in the following cycle; no write occurs; retired_cnt cleared.
- States: IDLE, DECODE, READ, EXEC, WRITE, DONE.
- Handshake:
  - instr_ready = 1 only in IDLE.
  - Transfer occurs on an edge where instr_valid & instr_ready; instr latched internally; next state DECODE.
  - instr_valid is ignored outside IDLE. The source may hold or change instr freely while busy.
- busy = 1 in every state except IDLE.
- All outputs except instr_ready and busy are registered.
- DECODE (1 cycle), outputs updated at exit edge:
  - alu_op = opcode; reg_c_addr = rc; reg_b_addr = rb.
  - R-type: reg_a_addr = field1; imm_sel = 0; imm = 0.
  - I-type: imm = {12'b0, field1}; imm_sel = 1; reg_a_addr = 0.
  - Opcode 11..15: no address/opcode outputs change; next state DONE with illegal set.
  - Otherwise next state READ.
- READ: lasts exactly RF_LAT cycles (down-counter), then EXEC.
- EXEC:
  - Lasts exactly ALU_LAT cycles.
  - On the exit edge, wr_data is loaded with alu_result; next state WRITE.
- WRITE: reg_we = 1 for exactly this one cycle; reg_c_addr and wr_data stable throughout; next state DONE.
- DONE:
  - done = 1 for one cycle; illegal = 1 in the same cycle if the opcode was illegal, else 0.
  - retired_cnt increments at the exit edge for legal instructions only; wraps 0xFFFF -> 0x0000.
  - Next state IDLE.
- Address/imm/alu_op outputs hold their last values in IDLE. They change only in DECODE.
- Latency with defaults: accept edge T0; reg_we high in cycle T0+4; done high in cycle T0+5; instr_ready high again from T0+6.
  - General: done at T0 + 3 + RF_LAT + ALU_LAT.
  - Illegal: done at T0+2.
- Back-to-back: with instr_valid held high, a new instruction is accepted on the first IDLE edge. Throughput is one instruction per 4 + RF_LAT + ALU_LAT cycles.
- Only one reg_we pulse per legal instruction; never any write for an illegal instruction.

Test Plan:
- Reset then ADD: instr = 0x0312 (op0, rc=3, ra=1, rb=2), alu_result model = 0x0007 -> reg_a_addr = 1, reg_b_addr = 2, reg_c_addr = 3, imm_sel = 0; single reg_we pulse in cycle T0+4 with wr_data = 0x0007; done at T0+5; retired_cnt = 1.
- I-type: instr = 0x6A5B (op6, rc=A, imm=5, rb=B) -> imm = 0x0005, imm_sel = 1, alu_op = 6, reg_c_addr = 0xA; one write.
- Illegal: instr = 0xC123 -> no reg_we; done and illegal high at T0+2; retired_cnt unchanged; alu_op keeps its prior value.
- Latency params: RF_LAT = 3, ALU_LAT = 2 -> done at T0+8; wr_data equals alu_result sampled at EXEC exit, not earlier values (model changes result every cycle).
- Reset mid-op: drop rst_n during EXEC -> outputs reset next edge; no reg_we ever asserted; instr_ready = 1 after reset released.
- Back-to-back and wrap: 3 instructions with instr_valid held high -> accepts spaced 6 cycles apart, instr changes ignored while busy; preset retired_cnt via 65536 retirements (or force) -> wraps to 0.
